// File: rtl/posit_pkg.sv
// Shared types and constant helpers for the posit leading-run detector.
package posit_pkg;

    typedef enum logic {LZC_MODE = 1'b0, RUN_MODE = 1'b1} run_mode_t;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/posit_run_core.sv
// Combinational leading-run counter: log-depth priority tree over a per-bit
// "still in the run" vector, padded at the bottom so the count saturates at W.
module posit_run_core
    import posit_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    input  run_mode_t     mode,
    output logic [CW-1:0] cnt,
    output logic          all
);

    localparam int L  = clog2(W);
    localparam int P  = 1 << L;
    localparam int LW = L + 1;

    logic [P-1:0]  run_s;
    logic [LW-1:0] node_cnt_s [P];
    logic          node_all_s [P];

    // Run vector: a set bit continues the leading run; padding bits never do.
    always_comb begin
        run_s = '0;
        if (mode == RUN_MODE) begin
            run_s[P-1 -: W] = ~(data ^ {W{data[W-1]}});
        end else begin
            run_s[P-1 -: W] = ~data;
        end
    end

    // Pairwise merge, halving node count per level; node i covers a
    // 2^lvl-bit slice, higher index = more significant.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            node_cnt_s[i] = LW'(run_s[i]);
            node_all_s[i] = run_s[i];
        end
        for (int lvl = 1; lvl <= L; lvl++) begin
            for (int i = 0; i < (P >> lvl); i++) begin
                if (node_all_s[2*i+1]) begin
                    node_cnt_s[i] = LW'(32'd1 << (lvl - 1)) + node_cnt_s[2*i];
                end else begin
                    node_cnt_s[i] = node_cnt_s[2*i+1];
                end
                node_all_s[i] = node_all_s[2*i+1] & node_all_s[2*i];
            end
        end
    end

    assign cnt = CW'(node_cnt_s[0]);
    assign all = (cnt == CW'(W));

endmodule

// File: rtl/posit_run_detect_pipe.sv
// Pipelined leading-run detector / normaliser with valid/ready back-pressure.
// Optional input register, core count stage, then shift stage driving the outputs.
module posit_run_detect_pipe
    import posit_pkg::*;
#(
    parameter int W       = 16,
    parameter int TAGW    = 4,
    parameter int PIPE_IN = 0,
    parameter int CW      = clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_mode,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_cnt,
    output logic [W-1:0]    out_norm,
    output logic            out_all,
    output logic [TAGW-1:0] out_tag
);

    logic            core_valid_s;
    logic [W-1:0]    core_data_s;
    run_mode_t       core_mode_s;
    logic [TAGW-1:0] core_tag_s;
    logic [CW-1:0]   core_cnt_s;
    logic            core_all_s;

    logic            s1_valid_r;
    logic [CW-1:0]   s1_cnt_r;
    logic            s1_all_r;
    logic [W-1:0]    s1_data_r;
    logic [TAGW-1:0] s1_tag_r;

    logic            s1_load_s;
    logic            s2_load_s;
    logic [W-1:0]    shift_s;

    assign s2_load_s = ~out_valid | out_ready;
    assign s1_load_s = ~s1_valid_r | s2_load_s;

    generate
        if (PIPE_IN != 0) begin : g_pipe_in
            logic            s0_valid_r;
            logic [W-1:0]    s0_data_r;
            run_mode_t       s0_mode_r;
            logic [TAGW-1:0] s0_tag_r;
            logic            s0_load_s;

            assign s0_load_s = ~s0_valid_r | s1_load_s;
            assign in_ready  = s0_load_s;

            // Input register stage; payload only captured with a real operand.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_valid_r <= 1'b0;
                    s0_data_r  <= '0;
                    s0_mode_r  <= LZC_MODE;
                    s0_tag_r   <= '0;
                end else if (s0_load_s) begin
                    s0_valid_r <= in_valid;
                    if (in_valid) begin
                        s0_data_r <= in_data;
                        s0_mode_r <= run_mode_t'(in_mode);
                        s0_tag_r  <= in_tag;
                    end
                end
            end

            assign core_valid_s = s0_valid_r;
            assign core_data_s  = s0_data_r;
            assign core_mode_s  = s0_mode_r;
            assign core_tag_s   = s0_tag_r;
        end else begin : g_no_pipe_in
            assign in_ready     = s1_load_s;
            assign core_valid_s = in_valid;
            assign core_data_s  = in_data;
            assign core_mode_s  = run_mode_t'(in_mode);
            assign core_tag_s   = in_tag;
        end
    endgenerate

    posit_run_core #(
        .W  (W),
        .CW (CW)
    ) u_core (
        .data (core_data_s),
        .mode (core_mode_s),
        .cnt  (core_cnt_s),
        .all  (core_all_s)
    );

    // Count stage: capture count, all-flag and operand for the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_cnt_r   <= '0;
            s1_all_r   <= 1'b0;
            s1_data_r  <= '0;
            s1_tag_r   <= '0;
        end else if (s1_load_s) begin
            s1_valid_r <= core_valid_s;
            if (core_valid_s) begin
                s1_cnt_r  <= core_cnt_s;
                s1_all_r  <= core_all_s;
                s1_data_r <= core_data_s;
                s1_tag_r  <= core_tag_s;
            end
        end
    end

    // Log barrel shifter; any stage shifting by >= W clears the word, so cnt==W gives 0.
    always_comb begin
        shift_s = s1_data_r;
        for (int b = 0; b < CW; b++) begin
            if (s1_cnt_r[b]) begin
                shift_s = shift_s << (32'd1 << b);
            end else begin
                shift_s = shift_s;
            end
        end
    end

    // Output stage; holds everything while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_cnt   <= '0;
            out_norm  <= '0;
            out_all   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_cnt  <= s1_cnt_r;
                out_norm <= shift_s;
                out_all  <= s1_all_r;
                out_tag  <= s1_tag_r;
            end
        end
    end

endmodule

// File: tb/tb_posit_run_detect_pipe.sv
// Scoreboard bench: a 16-bit no-input-register instance and a 64-bit PIPE_IN=1 instance.
module tb_posit_run_detect_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_all;
    logic [15:0] a_in_data, a_out_norm;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [4:0]  a_out_cnt;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_all;
    logic [63:0] b_in_data, b_out_norm;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [6:0]  b_out_cnt;

    posit_run_detect_pipe #(.W(16), .TAGW(4), .PIPE_IN(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_cnt(a_out_cnt),
        .out_norm(a_out_norm), .out_all(a_out_all), .out_tag(a_out_tag)
    );

    posit_run_detect_pipe #(.W(64), .TAGW(4), .PIPE_IN(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cnt(b_out_cnt),
        .out_norm(b_out_norm), .out_all(b_out_all), .out_tag(b_out_tag)
    );

    typedef struct {
        logic [63:0] norm;
        int          cnt;
        logic        all;
        logic [3:0]  tag;
        longint      t;
        bit          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int passes = 0;
    int rmode  = 0;
    int pi     = 0;
    logic [3:0] pat = 4'b1001;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endfunction

    // Reference: walk from the MSB counting bits equal to the run value.
    function automatic exp_t model(input logic [63:0] d, input int w, input logic m,
                                   input logic [3:0] tag, input bit lat);
        exp_t e;
        logic target;
        logic [63:0] mask;
        int n;
        target = m ? d[w-1] : 1'b0;
        n = 0;
        while (n < w && d[w-1-n] == target) n++;
        mask = {64{1'b1}} >> (64 - w);
        e.cnt  = n;
        e.all  = (n == w);
        e.norm = (n >= w) ? 64'd0 : ((d << n) & mask);
        e.tag  = tag;
        e.t    = longint'($time);
        e.lat  = lat;
        return e;
    endfunction

    task automatic send_a(input logic [15:0] d, input logic m, input logic [3:0] t, input bit lat);
        int n;
        a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_in_tag = t;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
        if (!a_in_ready) chk("a_accept_timeout", a_in_ready, 1);
        else begin @(posedge clk); qa.push_back(model({48'd0, d}, 16, m, t, lat)); end
        #1;
    endtask

    task automatic send_b(input logic [63:0] d, input logic m, input logic [3:0] t);
        int n;
        b_in_valid = 1'b1; b_in_data = d; b_in_mode = m; b_in_tag = t;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
        if (!b_in_ready) chk("b_accept_timeout", b_in_ready, 1);
        else begin @(posedge clk); qb.push_back(model(d, 64, m, t, 1'b1)); end
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin @(posedge clk); n++; end
        chk("drain_timeout", qa.size() + qb.size(), 0);
        #1;
    endtask

    function automatic logic [63:0] rand_run(input int w);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d = d >> (64 - w);
        d = d >> $urandom_range(0, w);
        if ($urandom % 2 == 1) d = ~d & ({64{1'b1}} >> (64 - w));
        return d;
    endfunction

    // Output-ready driver for instance a.
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: a_out_ready = 1'b1;
                1: begin a_out_ready = pat[pi]; pi = (pi + 1) % 4; end
                2: a_out_ready = 1'($urandom % 2);
                default: ;
            endcase
        end
    end

    exp_t ea;
    logic a_stall;
    logic [15:0] s_norm;
    logic [4:0]  s_cnt;
    logic        s_all;
    logic [3:0]  s_tag;

    // Monitor a: ready rule, hold-while-stalled, in-order pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_stall <= 1'b0;
        end else begin
            chk("a_in_ready", a_in_ready, (qa.size() < 2) || a_out_ready);
            if (a_stall) begin
                chk("a_hold_valid", a_out_valid, 1);
                chk("a_hold_norm", a_out_norm, s_norm);
                chk("a_hold_cnt", a_out_cnt, s_cnt);
                chk("a_hold_all", a_out_all, s_all);
                chk("a_hold_tag", a_out_tag, s_tag);
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", a_out_valid, 0);
                else begin
                    ea = qa.pop_front();
                    chk("a_cnt", a_out_cnt, ea.cnt);
                    chk("a_norm", a_out_norm, ea.norm);
                    chk("a_all", a_out_all, ea.all);
                    chk("a_tag", a_out_tag, ea.tag);
                    if (ea.lat) chk("a_latency", longint'($time) - ea.t, 15);
                end
            end
            a_stall <= a_out_valid && !a_out_ready;
            s_norm <= a_out_norm; s_cnt <= a_out_cnt; s_all <= a_out_all; s_tag <= a_out_tag;
        end
    end

    exp_t eb;
    // Monitor b: full-rate stream with fixed 3-cycle latency.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("b_in_ready", b_in_ready, (qb.size() < 3) || b_out_ready);
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("b_unexpected_out", b_out_valid, 0);
                else begin
                    eb = qb.pop_front();
                    chk("b_cnt", b_out_cnt, eb.cnt);
                    chk("b_norm", b_out_norm, eb.norm);
                    chk("b_all", b_out_all, eb.all);
                    chk("b_tag", b_out_tag, eb.tag);
                    chk("b_latency", longint'($time) - eb.t, 25);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] dir_d [0:6] = '{16'hFFF2, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000, 16'h0001, 16'h8000};
    logic        dir_m [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        longint t0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_in_tag = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_tag = '0;
        b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", a_out_valid, 0); chk("rst_a_cnt", a_out_cnt, 0);
        chk("rst_a_norm", a_out_norm, 0);   chk("rst_a_all", a_out_all, 0);
        chk("rst_a_tag", a_out_tag, 0);     chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_norm", b_out_norm, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("a_ready_after_rst", a_in_ready, 1);
        chk("b_ready_after_rst", b_in_ready, 1);

        send_a(16'h0F00, 1'b0, 4'd3, 1'b1);
        a_in_valid = 1'b0;
        drain();

        for (int i = 0; i < 7; i++) send_a(dir_d[i], dir_m[i], 4'(i), 1'b1);
        a_in_valid = 1'b0;
        drain();

        rmode = 1; pi = 0;
        for (int i = 0; i < 8; i++) send_a(16'(rand_run(16)), 1'(i % 2), 4'(i + 8), 1'b0);
        a_in_valid = 1'b0;
        drain();

        rmode = 2;
        for (int i = 0; i < 300; i++) begin
            send_a(16'(rand_run(16)), 1'($urandom % 2), 4'($urandom), 1'b0);
            if ($urandom % 4 == 0) begin a_in_valid = 1'b0; @(posedge clk); #1; end
        end
        a_in_valid = 1'b0;
        rmode = 0;
        drain();

        rmode = 3;
        a_out_ready = 1'b0;
        send_a(16'h00F0, 1'b0, 4'd1, 1'b0);
        send_a(16'hF0F0, 1'b1, 4'd2, 1'b0);
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("flush_out_valid", a_out_valid, 0);
        chk("flush_in_ready", a_in_ready, 1);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        rmode = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_out", a_out_valid, 0);
        end
        @(posedge clk); #1;

        t0 = longint'($time);
        for (int i = 0; i < 10000; i++) send_b(rand_run(64), 1'($urandom % 2), 4'($urandom));
        chk("b_throughput", longint'($time) - t0, 100000);
        b_in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
